// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU run controller and the data-memory dump path.
package cpu_ctrl_pkg;

  localparam int CPU_ADDR_W    = 9;
  localparam int CPU_DATA_W    = 32;
  localparam int CPU_MEM_WORDS = 512;

  localparam logic [31:0] CPU_HALT_WORD = 32'hFFFF_FFFF;

  typedef logic [2:0] run_state_t;

  localparam run_state_t ST_IDLE  = 3'd0;
  localparam run_state_t ST_RUN   = 3'd1;
  localparam run_state_t ST_DRAIN = 3'd2;
  localparam run_state_t ST_DUMP  = 3'd3;
  localparam run_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/mem_dump_streamer.sv
// Streams every data-memory word out over valid/ready while start_dump is held.
// dump_valid/dump_ready: a word transfers on any rising edge where both are 1;
// dump_data/dump_index stay stable while dump_valid=1 and dump_ready=0.
module mem_dump_streamer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = CPU_MEM_WORDS,
  parameter int ADDR_W    = CPU_ADDR_W,
  parameter int DATA_W    = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_dump,
  output logic              dump_finished,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index
);

  localparam logic [ADDR_W:0]   WORDS    = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_WORDS - 1);

  // One extra bit lets next_addr reach MEM_WORDS without wrapping to 0.
  logic [ADDR_W:0]   next_addr;
  logic              in_flight;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              issue;

  always_comb begin
    issue = start_dump && !in_flight && (!dump_valid || dump_ready) && (next_addr < WORDS);
  end

  assign mem_rd_en     = issue;
  assign mem_rd_addr   = next_addr[ADDR_W-1:0];
  assign dump_finished = dump_valid && dump_ready && (dump_index == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset || !start_dump) begin
      next_addr  <= '0;
      in_flight  <= 1'b0;
      rd_addr_q  <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_index <= '0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        next_addr <= next_addr + 1'b1;
        rd_addr_q <= mem_rd_addr;
      end
      // A read in flight implies the output register is free this cycle.
      if (in_flight) begin
        dump_valid <= 1'b1;
        dump_data  <= mem_rd_data;
        dump_index <= rd_addr_q;
      end else if (dump_valid && dump_ready) begin
        dump_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run sequencer: start -> run until halt word -> drain -> dump data memory -> done.
// Optional watchdog (forces drain after MAX_CYCLES run cycles) under CPU_RUN_WATCHDOG_EN.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
`ifdef CPU_RUN_WATCHDOG_EN
  parameter logic [31:0] MAX_CYCLES = 32'd100000,
`endif
  parameter logic [31:0] HALT_WORD    = CPU_HALT_WORD,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          MEM_WORDS    = CPU_MEM_WORDS,
  parameter int          ADDR_W       = CPU_ADDR_W,
  parameter int          DATA_W       = CPU_DATA_W
) (
  input  logic              CLOCK,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       ifid_instruction,
  output logic              cpu_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic [31:0]       cycle_count,
  output logic              busy,
  output logic              done,
`ifdef CPU_RUN_WATCHDOG_EN
  output logic              timeout,
`endif
  output run_state_t        dbg_state
);

  localparam logic [31:0] DRAIN_N = 32'(DRAIN_CYCLES);

  run_state_t  state;
  logic [31:0] drain_cnt;
  logic        halt_seen;
  logic        wdog_hit;
  logic        dump_finished;

  assign halt_seen = (ifid_instruction == HALT_WORD);
`ifdef CPU_RUN_WATCHDOG_EN
  // True on the run cycle that brings cycle_count up to MAX_CYCLES.
  assign wdog_hit = (cycle_count >= MAX_CYCLES - 32'd1);
`else
  assign wdog_hit = 1'b0;
`endif

  assign cpu_en    = (state == ST_RUN) || (state == ST_DRAIN);
  assign busy      = cpu_en || (state == ST_DUMP);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state       <= ST_IDLE;
      cycle_count <= '0;
      drain_cnt   <= '0;
`ifdef CPU_RUN_WATCHDOG_EN
      timeout     <= 1'b0;
`endif
    end else begin
      if (cpu_en && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;
      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN: begin
          if (halt_seen || wdog_hit) begin
`ifdef CPU_RUN_WATCHDOG_EN
            if (!halt_seen) timeout <= 1'b1;
`endif
            if (DRAIN_N == 32'd0) begin
              state <= ST_DUMP;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_N;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt <= 32'd1) state <= ST_DUMP;
          else                    drain_cnt <= drain_cnt - 32'd1;
        end
        ST_DUMP: if (dump_finished) state <= ST_DONE;
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_dump_streamer #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) u_streamer (
    .clk           (CLOCK),
    .reset         (reset),
    .start_dump    (state == ST_DUMP),
    .dump_finished (dump_finished),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_data     (dump_data),
    .dump_index    (dump_index)
  );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: scripted run/drain sequences plus a dump scoreboard
// fed from a behavioural memory model and checked by an independent monitor.
module tb_cpu_run_controller;

  localparam int          MEM_WORDS = 512;
  localparam int          ADDR_W    = 9;
  localparam int          DATA_W    = 32;
  localparam int          DRAIN     = 3;
  localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

  logic              CLOCK;
  logic              reset;
  logic              start;
  logic [31:0]       ifid_instruction;
  logic              cpu_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_index;
  logic [31:0]       cycle_count;
  logic              busy;
  logic              done;
`ifdef CPU_RUN_WATCHDOG_EN
  logic              timeout;
`endif
  logic [2:0]        dbg_state;

  // ---------------- clock / reset ----------------
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  cpu_run_controller dut (
    .CLOCK            (CLOCK),
    .reset            (reset),
    .start            (start),
    .ifid_instruction (ifid_instruction),
    .cpu_en           (cpu_en),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .dump_valid       (dump_valid),
    .dump_ready       (dump_ready),
    .dump_data        (dump_data),
    .dump_index       (dump_index),
    .cycle_count      (cycle_count),
    .busy             (busy),
    .done             (done),
`ifdef CPU_RUN_WATCHDOG_EN
    .timeout          (timeout),
`endif
    .dbg_state        (dbg_state)
  );

  // Synchronous data memory model
  logic [DATA_W-1:0] mem [MEM_WORDS];
  always @(posedge CLOCK) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W+ADDR_W-1:0] exp_q[$];
  int ready_mode = 0;
  int stall_left = 0;
  int stall_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] nonhalt();
    logic [31:0] v;
    v = $urandom;
    if (v == HALT) v = 32'h0000_0013;
    return v;
  endfunction

  // ---------------- ready driver ----------------
  always @(posedge CLOCK) begin
    #1;
    case (ready_mode)
      1: dump_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (dump_valid && dump_index == 9'd7 && stall_left > 0) begin
          dump_ready = 1'b0;
          stall_left--;
        end else begin
          dump_ready = 1'b1;
        end
      end
      default: dump_ready = 1'b1;
    endcase
  end

  // ---------------- monitor ----------------
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_idx;
  always @(negedge CLOCK) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {dump_valid, dump_data, dump_index}, {1'b1, prev_data, prev_idx});
      if (dump_valid && !dump_ready) begin
        check("no_read_in_stall", mem_rd_en, 1'b0);
        if (dump_index == 9'd7) stall_seen++;
      end
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", {dump_data, dump_index}, 64'hDEAD);
        else check("dump_word", {dump_data, dump_index}, exp_q.pop_front());
      end
      prev_stall = dump_valid && !dump_ready;
      prev_data  = dump_data;
      prev_idx   = dump_index;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_en"},      cpu_en, 0);
    check({tag, "_mem_rd_en"},   mem_rd_en, 0);
    check({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
    check({tag, "_dump_valid"},  dump_valid, 0);
    check({tag, "_dump_data"},   dump_data, 0);
    check({tag, "_dump_index"},  dump_index, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_done"},        done, 0);
    check({tag, "_state_idle"},  dbg_state, 0);
  endtask

  // One full run: halt on run cycle k, dump with the given ready mode.
  task automatic run_one(input int k, input int mode, input bit pattern3, input int abort_idx);
    int n;
    bit aborted;
    logic [31:0] final_count;
    exp_q.delete();
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = pattern3 ? 32'(i * 3) : $urandom;
      exp_q.push_back({mem[i], ADDR_W'(i)});
    end
    ready_mode = mode;
    stall_left = 5;
    stall_seen = 0;

    // Idle ignores halt words.
    for (int i = 0; i < 2; i++) begin
      ifid_instruction = HALT;
      check("idle_cpu_en", cpu_en, 0);
      tick();
    end
    start = 1'b1;
    ifid_instruction = nonhalt();
    tick();
    for (int i = 1; i <= k; i++) begin
      ifid_instruction = (i == k) ? HALT : nonhalt();
      start = 1'($urandom_range(0, 1));
      check("run_cpu_en", cpu_en, 1);
      check("run_count", cycle_count, i - 1);
      tick();
    end
    for (int j = 1; j <= DRAIN; j++) begin
      ifid_instruction = $urandom_range(0, 1) ? HALT : nonhalt();
      start = 1'($urandom_range(0, 1));
      check("drain_cpu_en", cpu_en, 1);
      check("drain_count", cycle_count, k + j - 1);
      tick();
    end
    start = 1'b0;
    final_count = 32'(k + DRAIN);
    check("dump_cpu_en", cpu_en, 0);
    check("dump_entry_count", cycle_count, final_count);
    check("first_rd_en", mem_rd_en, 1);
    check("first_rd_addr", mem_rd_addr, 0);

    n = 0;
    aborted = 1'b0;
    while (!done && n < 5000 && !aborted) begin
      ifid_instruction = $urandom;
      if (abort_idx >= 0 && dump_valid && dump_index == ADDR_W'(abort_idx)) begin
        do_reset();
        check_all_zero("abort");
        exp_q.delete();
        aborted = 1'b1;
      end else begin
        tick();
        n++;
      end
    end
    if (!aborted) begin
      check("done_reached", done, 1);
      check("final_count", cycle_count, final_count);
      check("busy_after_done", busy, 0);
      check("words_left", exp_q.size(), 0);
      if (mode == 0) check("dump_latency_in_range", (n >= 1022 && n <= 1026), 1);
      if (mode == 2) check("stall_cycles_idx7", stall_seen, 5);
      start = 1'b1;
      ifid_instruction = HALT;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("done_sticky", done, 1);
      check("done_count_frozen", cycle_count, final_count);
      check("done_cpu_en", cpu_en, 0);
      check("done_state", dbg_state, 3'd4);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    ifid_instruction = '0;
    dump_ready = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    reset = 1'b0;
    check_all_zero("reset");

    run_one(10, 0, 1'b1, -1);
    do_reset();
    run_one(20, 2, 1'b1, -1);
    do_reset();
    run_one(5, 0, 1'b0, 100);
    run_one($urandom_range(1, 40), 1, 1'b0, -1);
    do_reset();
    run_one(1, 1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Top-level run sequencer for the 5-stage pipelined CPU. It enables CPU clocking after start and counts executed cycles. It detects the halt word in the IF/ID instruction register and drains the pipeline for a fixed number of cycles. It then freezes the CPU and streams every data-memory word out over a valid/ready port, replacing the ad-hoc halt/drain/dump sequence in simulation with synthesizable control.

Parameters:
HALT_WORD, 32'hFFFFFFFF, instruction value in IF/ID that triggers halt
DRAIN_CYCLES, 3, CPU-enabled cycles after halt detection before freeze
MEM_WORDS, 512, number of data-memory words dumped
ADDR_W, 9, dump address width (clog2 of MEM_WORDS)
DATA_W, 32, data word width
MAX_CYCLES, 32'd100000, watchdog limit (used only with the optional feature)

Ports:
CLOCK  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  single-cycle pulse; begins execution from IDLE
ifid_instruction  in  32  current IF/ID pipeline-register instruction
cpu_en  out  1  CPU clock-enable / global stall release
mem_rd_en  out  1  data-memory dump read strobe
mem_rd_addr  out  ADDR_W  dump read address
mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en (sync RAM)
dump_valid  out  1  dump_data/dump_index valid
dump_ready  in  1  consumer accepts the word
dump_data  out  DATA_W  memory word
dump_index  out  ADDR_W  address of dump_data
cycle_count  out  32  cycles with cpu_en=1
busy  out  1  state is RUN, DRAIN or DUMP
done  out  1  dump complete

Behaviour:
- States: IDLE, RUN, DRAIN, DUMP, DONE. All registers update on the rising CLOCK edge.
- Reset (synchronous, active-high, any state including mid-dump): state=IDLE. All outputs and counters go to 0, including cpu_en, mem_rd_en, dump_valid, done and cycle_count.
- IDLE: cpu_en=0. When start=1, go to RUN next cycle. All other inputs are ignored.
- RUN: cpu_en=1. cycle_count increments every cycle. When ifid_instruction==HALT_WORD, go to DRAIN and load the drain counter with DRAIN_CYCLES. The detecting cycle counts as a run cycle.
- DRAIN: cpu_en=1 for exactly DRAIN_CYCLES cycles, with cycle_count incrementing. Halt words seen here are ignored. When the counter expires, go to DUMP with cpu_en=0 from the first DUMP cycle onward.
- DRAIN_CYCLES=0: go directly from RUN to DUMP.
- Total cycle_count = cycles from RUN entry up to and including the halt cycle, plus DRAIN_CYCLES.
- DUMP read issue: a read is issued (mem_rd_en=1, mem_rd_addr=next_addr) only when all of these hold:
  - no read is in flight;
  - (!dump_valid || dump_ready);
  - next_addr < MEM_WORDS.
- DUMP capture: the cycle after a read, mem_rd_data is captured into dump_data and the address into dump_index. dump_valid rises on the following edge.
- Handshake: dump_valid stays asserted with stable dump_data/dump_index until dump_valid&&dump_ready. Throughput is at most 1 word per 2 cycles.
- next_addr counter is ADDR_W+1 bits wide so it reaches MEM_WORDS without wrapping.
- After the handshake of index MEM_WORDS-1: dump_valid=0 and state goes to DONE.
- DONE: done=1 and cycle_count frozen. The block stays here until reset; start is ignored.
- cycle_count saturates at 32'hFFFFFFFF.
- start arriving in any state other than IDLE has no effect.

Optional Feature:
CPU_RUN_WATCHDOG_EN
- Defined:
  - If cycle_count reaches MAX_CYCLES in RUN without a halt word, the block enters DRAIN exactly as on a halt.
  - Adds output timeout (1 bit), set on that transition. It holds until reset.
  - A halt seen in the same cycle takes priority, and timeout stays 0.
- Undefined: the timeout port is absent, and RUN continues indefinitely until the halt word.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DUMP, DONE);
  - the HALT_WORD default constant;
  - the address/data width localparams shared with the data memory.
- One natural sub-module: mem_dump_streamer. It covers the DUMP read-issue, in-flight and valid/ready logic, with start_dump and dump_finished handshake to the parent FSM.

Test Plan:
- Reset then start; halt appears in IF/ID on the 10th RUN cycle -> cpu_en high for 13 cycles, cycle_count=13, then cpu_en=0 and the first mem_rd_en is at addr 0.
- MEM_WORDS=512 with memory word i = i*3 and dump_ready tied high -> 512 words in index order with dump_data=3*i; done is asserted 1024±2 cycles after DUMP entry.
- Backpressure: dump_ready low for 5 cycles on index 7 -> dump_data/dump_index hold 21/7 stable, no mem_rd_en during the stall, and no word is lost or duplicated.
- Reset asserted mid-dump at index 100 -> next cycle state=IDLE, all outputs 0; a subsequent start reruns, and cycle_count restarts from 0.
- start pulses during RUN and DONE, and halt words during DRAIN -> no state change, and cycle_count is unaffected beyond normal counting.
- With CPU_RUN_WATCHDOG_EN and MAX_CYCLES=50, no halt word -> timeout=1 and drain begins when cycle_count=50; final cycle_count=53, then a full dump.
